// File: rtl/forth_data_stack_if.sv
// Decoder/ALU-facing bundle of the FORTH data stack: op strobe, literal and
// ALU result in, operands and stack status out.
interface forth_data_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [2:0]       stack_op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] alu_result;
    logic             err_clr;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic             alu_ena;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output op_valid, stack_op, din, alu_result, err_clr,
        input  tos, nos, alu_ena, depth, full, empty, overflow, underflow
    );

    modport slave (
        input  op_valid, stack_op, din, alu_result, err_clr,
        output tos, nos, alu_ena, depth, full, empty, overflow, underflow
    );
endinterface

// File: rtl/forth_data_stack.sv
// FORTH data stack feeding the ALU: one primitive per clock, tos/nos as ALU
// operands, ALU result written back on BINOP/UNOP, sticky bound errors.
module forth_data_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    forth_data_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_PUSH  = 3'b001,
        OP_DROP  = 3'b010,
        OP_DUP   = 3'b011,
        OP_SWAP  = 3'b100,
        OP_OVER  = 3'b101,
        OP_BINOP = 3'b110,
        OP_UNOP  = 3'b111
    } stack_op_t;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DW-1:0]    depth_reg, depth_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    stack_op_t        op;
    logic [DW-1:0]    need_u;
    logic             has_o;
    logic             under_err, over_err, exec;
    logic [DW-1:0]    depth_m1, depth_m2;
    logic [PW-1:0]    top_idx, nos_idx, push_idx;
    logic [WIDTH-1:0] top_val, nos_val;

    logic             wr_a_en, wr_b_en;
    logic [PW-1:0]    wr_a_idx, wr_b_idx;
    logic [WIDTH-1:0] wr_a_data, wr_b_data;
    logic [DEPTH-1:0] we_a, we_b;

    assign op       = stack_op_t'(bus.stack_op);
    assign depth_m1 = depth_reg - DW'(1);
    assign depth_m2 = depth_reg - DW'(2);
    assign top_idx  = depth_m1[PW-1:0];
    assign nos_idx  = depth_m2[PW-1:0];
    assign push_idx = depth_reg[PW-1:0];
    assign top_val  = mem_reg[top_idx];
    assign nos_val  = mem_reg[nos_idx];

    always_comb begin
        need_u = '0;
        has_o  = 1'b0;
        case (op)
            OP_PUSH:  has_o = 1'b1;
            OP_DROP:  need_u = DW'(1);
            OP_DUP:   begin need_u = DW'(1); has_o = 1'b1; end
            OP_SWAP:  need_u = DW'(2);
            OP_OVER:  begin need_u = DW'(2); has_o = 1'b1; end
            OP_BINOP: need_u = DW'(2);
            OP_UNOP:  need_u = DW'(1);
            default:  ;
        endcase
    end

    // Underflow takes priority, so an op can only ever raise one flag.
    assign under_err = bus.op_valid && (depth_reg < need_u);
    assign over_err  = bus.op_valid && !under_err && has_o && (depth_reg == DW'(DEPTH));
    assign exec      = bus.op_valid && !under_err && !over_err;

    always_comb begin
        wr_a_en    = 1'b0;
        wr_a_idx   = top_idx;
        wr_a_data  = top_val;
        wr_b_en    = 1'b0;
        wr_b_idx   = nos_idx;
        wr_b_data  = nos_val;
        depth_next = depth_reg;
        if (exec) begin
            case (op)
                OP_PUSH: begin
                    wr_a_en = 1'b1; wr_a_idx = push_idx; wr_a_data = bus.din;
                    depth_next = depth_reg + DW'(1);
                end
                OP_DROP: depth_next = depth_m1;
                OP_DUP: begin
                    wr_a_en = 1'b1; wr_a_idx = push_idx; wr_a_data = top_val;
                    depth_next = depth_reg + DW'(1);
                end
                OP_SWAP: begin
                    wr_a_en = 1'b1; wr_a_idx = top_idx; wr_a_data = nos_val;
                    wr_b_en = 1'b1; wr_b_idx = nos_idx; wr_b_data = top_val;
                end
                OP_OVER: begin
                    wr_a_en = 1'b1; wr_a_idx = push_idx; wr_a_data = nos_val;
                    depth_next = depth_reg + DW'(1);
                end
                OP_BINOP: begin
                    wr_a_en = 1'b1; wr_a_idx = nos_idx; wr_a_data = bus.alu_result;
                    depth_next = depth_m1;
                end
                OP_UNOP: begin
                    wr_a_en = 1'b1; wr_a_idx = top_idx; wr_a_data = bus.alu_result;
                end
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as err_clr leaves its flag set.
    always_comb begin
        overflow_next  = bus.err_clr ? 1'b0 : overflow_reg;
        underflow_next = bus.err_clr ? 1'b0 : underflow_reg;
        if (over_err)  overflow_next  = 1'b1;
        if (under_err) underflow_next = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_a[gi] = wr_a_en && (wr_a_idx == PW'(gi));
            assign we_b[gi] = wr_b_en && (wr_b_idx == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_a[i])      mem_reg[i] <= wr_a_data;
                else if (we_b[i]) mem_reg[i] <= wr_b_data;
            end
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.tos       = (depth_reg != '0) ? top_val : '0;
    assign bus.nos       = (depth_reg >= DW'(2)) ? nos_val : '0;
    assign bus.alu_ena   = bus.op_valid && ((op == OP_BINOP) || (op == OP_UNOP)) && !under_err;
    assign bus.depth     = depth_reg;
    assign bus.full      = (depth_reg == DW'(DEPTH));
    assign bus.empty     = (depth_reg == '0);
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule
